// File: rtl/pc_pkg.sv
// Shared branch-mode encodings and offset helper for the program-counter sequencer.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ  = 3'b000,
    PC_BEQ  = 3'b001,
    PC_BNE  = 3'b010,
    PC_JUMP = 3'b011,
    PC_CALL = 3'b100,
    PC_RET  = 3'b101,
    PC_JREG = 3'b110,
    PC_RSVD = 3'b111
  } branch_mode_e;

  localparam int PC_STEP  = 4;
  localparam int PC_MAX_W = 64;

  // Sign-extends the low offsetW bits of a word offset and scales it to bytes.
  function automatic logic [PC_MAX_W-1:0] offsetToBytes(input logic [PC_MAX_W-1:0] offset,
                                                        input int unsigned        offsetW);
    logic signed [PC_MAX_W-1:0] ext;
    ext = offset << (PC_MAX_W - offsetW);
    ext = ext >>> (PC_MAX_W - offsetW);
    return ext << 2;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry;
// callers derive overflow/underflow from full/empty.
module pc_ras #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] top,
  output logic              empty,
  output logic              full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_ptr;
  logic [CNT_W-1:0]  r_count;

  assign empty = (r_count == '0);
  assign full  = (r_count == CNT_W'(DEPTH));
  assign top   = r_mem[r_ptr - PTR_W'(1)];

  // Contents need no reset: the count gates every meaningful read.
  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + PTR_W'(1);
      if (!full) begin
        r_count <= r_count + CNT_W'(1);
      end
    end else if (pop && !empty) begin
      r_ptr   <= r_ptr - PTR_W'(1);
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_seq_unit.sv
// Program-counter sequencer: sequential, BEQ/BNE, JUMP, JREG and CALL/RET via pc_ras.
// Defining PC_MISALIGN_TRAP_EN redirects misaligned targets to TRAP_VECTOR and adds MISALIGN.
module pc_seq_unit
  import pc_pkg::*;
#(
  parameter int                ADDR_W       = 32,
  parameter int                OFFSET_W     = 8,
  parameter int                RAS_DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
`ifdef PC_MISALIGN_TRAP_EN
  , parameter logic [ADDR_W-1:0] TRAP_VECTOR = ADDR_W'('h10)
`endif
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                STALL,
  input  logic [2:0]          BRANCH,
  input  logic                ZERO,
  input  logic [OFFSET_W-1:0] OFFSET,
  input  logic [ADDR_W-1:0]   JREG_TARGET,
  output logic [ADDR_W-1:0]   PC,
  output logic [ADDR_W-1:0]   NEXT_PC,
  output logic                TAKEN,
  output logic                RAS_OVF,
  output logic                RAS_UNF
`ifdef PC_MISALIGN_TRAP_EN
  , output logic              MISALIGN
`endif
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_ovf;
  logic              r_unf;

  logic [ADDR_W-1:0] w_seqPc;
  logic [ADDR_W-1:0] w_relOff;
  logic [ADDR_W-1:0] w_relPc;
  logic [ADDR_W-1:0] w_sel;
  logic [ADDR_W-1:0] w_next;
  logic [ADDR_W-1:0] w_rasTop;
  logic              w_rasEmpty;
  logic              w_rasFull;
  logic              w_redirect;
  logic              w_taken;
  logic              w_push;
  logic              w_pop;
  logic              w_pushEn;
  logic              w_popEn;

  assign w_seqPc  = r_pc + ADDR_W'(PC_STEP);
  assign w_relOff = ADDR_W'(offsetToBytes(PC_MAX_W'(OFFSET), OFFSET_W));
  assign w_relPc  = w_seqPc + w_relOff;

  // Source selection; w_redirect marks any source other than the sequential one.
  always_comb begin
    w_sel      = w_seqPc;
    w_redirect = 1'b0;
    w_push     = 1'b0;
    w_pop      = 1'b0;
    case (BRANCH)
      PC_BEQ: begin
        if (ZERO) begin
          w_sel      = w_relPc;
          w_redirect = 1'b1;
        end
      end
      PC_BNE: begin
        if (!ZERO) begin
          w_sel      = w_relPc;
          w_redirect = 1'b1;
        end
      end
      PC_JUMP: begin
        w_sel      = w_relPc;
        w_redirect = 1'b1;
      end
      PC_CALL: begin
        w_sel      = w_relPc;
        w_redirect = 1'b1;
        w_push     = 1'b1;
      end
      PC_RET: begin
        w_pop = 1'b1;
        if (!w_rasEmpty) begin
          w_sel      = w_rasTop;
          w_redirect = 1'b1;
        end
      end
      PC_JREG: begin
        w_sel      = JREG_TARGET;
        w_redirect = 1'b1;
      end
      default: begin
        w_sel = w_seqPc;
      end
    endcase
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_misalign;

  // A misaligned target is replaced by the trap vector and suppresses a CALL push.
  always_comb begin
    w_misalign = (w_sel[1:0] != 2'b00);
    w_next     = w_misalign ? TRAP_VECTOR : w_sel;
    w_taken    = w_redirect | w_misalign;
    w_pushEn   = w_push & ~w_misalign & ~STALL;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_misalign <= 1'b0;
    end else if (!STALL && w_misalign) begin
      r_misalign <= 1'b1;
    end
  end

  assign MISALIGN = r_misalign;
`else
  assign w_next   = w_sel;
  assign w_taken  = w_redirect;
  assign w_pushEn = w_push & ~STALL;
`endif

  assign w_popEn = w_pop & ~STALL;

  pc_ras #(
    .DEPTH  (RAS_DEPTH),
    .DATA_W (ADDR_W)
  ) u_ras (
    .clk       (CLK),
    .rst_n     (RESET),
    .push      (w_pushEn),
    .pop       (w_popEn),
    .push_data (w_seqPc),
    .top       (w_rasTop),
    .empty     (w_rasEmpty),
    .full      (w_rasFull)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_pc  <= RESET_VECTOR;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!STALL) begin
      r_pc  <= w_next;
      r_ovf <= r_ovf | (w_pushEn & w_rasFull);
      r_unf <= r_unf | (w_popEn & w_rasEmpty);
    end
  end

  assign PC      = r_pc;
  assign NEXT_PC = w_next;
  assign TAKEN   = w_taken;
  assign RAS_OVF = r_ovf;
  assign RAS_UNF = r_unf;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Scoreboard bench for pc_seq_unit: a queue-based reference model predicts each cycle,
// a monitor process compares the DUT against it.
module tb_pc_seq_unit;

  logic        CLK;
  logic        RESET;
  logic        STALL;
  logic [2:0]  BRANCH;
  logic        ZERO;
  logic [7:0]  OFFSET;
  logic [31:0] JREG_TARGET;
  logic [31:0] PC;
  logic [31:0] NEXT_PC;
  logic        TAKEN;
  logic        RAS_OVF;
  logic        RAS_UNF;

  typedef struct {
    logic [31:0] nextPc;
    logic        taken;
    logic [31:0] pc;
    logic        ovf;
    logic        unf;
  } expect_t;

  expect_t     expQ[$];
  logic [31:0] mStack[$];
  logic [31:0] mPc;
  logic        mOvf;
  logic        mUnf;
  int          assertCount = 0;
  int          failCount   = 0;

  pc_seq_unit #(
    .ADDR_W       (32),
    .OFFSET_W     (8),
    .RAS_DEPTH    (4),
    .RESET_VECTOR (32'h0)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .STALL       (STALL),
    .BRANCH      (BRANCH),
    .ZERO        (ZERO),
    .OFFSET      (OFFSET),
    .JREG_TARGET (JREG_TARGET),
    .PC          (PC),
    .NEXT_PC     (NEXT_PC),
    .TAKEN       (TAKEN),
    .RAS_OVF     (RAS_OVF),
    .RAS_UNF     (RAS_UNF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a bounded LIFO where overflow drops the oldest return address.
  task automatic modelStep(input logic st, input logic [2:0] br, input logic z,
                           input logic [7:0] off, input logic [31:0] jt, output expect_t e);
    logic [31:0] seqPc, relPc, nxt;
    logic        tk;
    int          offInt;
    seqPc  = mPc + 32'd4;
    offInt = int'($signed(off));
    relPc  = seqPc + 32'(offInt * 4);
    nxt    = seqPc;
    tk     = 1'b0;
    case (br)
      3'd1: if (z)  begin nxt = relPc; tk = 1'b1; end
      3'd2: if (!z) begin nxt = relPc; tk = 1'b1; end
      3'd3: begin nxt = relPc; tk = 1'b1; end
      3'd4: begin
        nxt = relPc;
        tk  = 1'b1;
        if (!st) begin
          mStack.push_back(seqPc);
          if (mStack.size() > 4) begin
            void'(mStack.pop_front());
            mOvf = 1'b1;
          end
        end
      end
      3'd5: begin
        if (mStack.size() > 0) begin
          nxt = mStack[$];
          tk  = 1'b1;
          if (!st) void'(mStack.pop_back());
        end else if (!st) begin
          mUnf = 1'b1;
        end
      end
      3'd6: begin nxt = jt; tk = 1'b1; end
      default: nxt = seqPc;
    endcase
    e.nextPc = nxt;
    e.taken  = tk;
    if (!st) mPc = nxt;
    e.pc  = mPc;
    e.ovf = mOvf;
    e.unf = mUnf;
  endtask

  task automatic applyStimulus(input logic st, input logic [2:0] br, input logic z,
                               input logic [7:0] off, input logic [31:0] jt);
    expect_t e;
    @(negedge CLK);
    STALL       = st;
    BRANCH      = br;
    ZERO        = z;
    OFFSET      = off;
    JREG_TARGET = jt;
    modelStep(st, br, z, off, jt, e);
    expQ.push_back(e);
  endtask

  task automatic expectPc(input string name, input logic [31:0] value);
    @(posedge CLK);
    #2;
    checkOutput(name, PC, value);
  endtask

  // Asynchronous reset pulse while the clock is high, away from any edge.
  task automatic resetPulse();
    @(posedge CLK);
    #2;
    RESET = 1'b0;
    #1;
    checkOutput("async_reset_pc", PC, 32'h0);
    checkOutput("async_reset_ovf", 32'(RAS_OVF), 32'h0);
    checkOutput("async_reset_unf", 32'(RAS_UNF), 32'h0);
    mPc  = 32'h0;
    mOvf = 1'b0;
    mUnf = 1'b0;
    mStack.delete();
    #1;
    RESET = 1'b1;
  endtask

  // Monitor: combinational outputs mid-low-phase, registered state just after the edge.
  initial begin
    expect_t e;
    forever begin
      @(negedge CLK);
      #3;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("next_pc", NEXT_PC, e.nextPc);
        checkOutput("taken", 32'(TAKEN), 32'(e.taken));
        @(posedge CLK);
        #1;
        checkOutput("pc", PC, e.pc);
        checkOutput("ras_ovf", 32'(RAS_OVF), 32'(e.ovf));
        checkOutput("ras_unf", 32'(RAS_UNF), 32'(e.unf));
      end
    end
  end

  initial begin
    RESET       = 1'b0;
    STALL       = 1'b0;
    BRANCH      = 3'd0;
    ZERO        = 1'b0;
    OFFSET      = 8'h0;
    JREG_TARGET = 32'h0;
    mPc         = 32'h0;
    mOvf        = 1'b0;
    mUnf        = 1'b0;
    #3;
    checkOutput("reset_pc", PC, 32'h0);
    checkOutput("reset_ovf", 32'(RAS_OVF), 32'h0);
    checkOutput("reset_unf", 32'(RAS_UNF), 32'h0);
    #4;
    RESET = 1'b1;

    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 3'd0, 1'b0, 8'h00, 32'h0);
      expectPc("seq_run", 32'(i * 4));
    end

    applyStimulus(1'b0, 3'd6, 1'b0, 8'h00, 32'h20);
    applyStimulus(1'b0, 3'd1, 1'b1, 8'hFE, 32'h0);
    expectPc("beq_taken", 32'h1C);
    applyStimulus(1'b0, 3'd6, 1'b0, 8'h00, 32'h20);
    applyStimulus(1'b0, 3'd1, 1'b0, 8'hFE, 32'h0);
    expectPc("beq_not_taken", 32'h24);
    applyStimulus(1'b0, 3'd2, 1'b0, 8'h03, 32'h0);
    expectPc("bne_taken", 32'h34);

    applyStimulus(1'b0, 3'd6, 1'b0, 8'h00, 32'h40);
    applyStimulus(1'b0, 3'd4, 1'b0, 8'h04, 32'h0);
    expectPc("call", 32'h54);
    applyStimulus(1'b0, 3'd5, 1'b0, 8'h00, 32'h0);
    expectPc("ret", 32'h44);
    applyStimulus(1'b0, 3'd5, 1'b0, 8'h00, 32'h0);
    expectPc("ret_empty", 32'h48);
    checkOutput("ret_empty_unf", 32'(RAS_UNF), 32'h1);

    resetPulse();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 3'd4, 1'b0, 8'h03, 32'h0);
      expectPc("nested_call", 32'((i + 1) * 16));
    end
    checkOutput("overflow_flag", 32'(RAS_OVF), 32'h1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 3'd5, 1'b0, 8'h00, 32'h0);
      expectPc("nested_ret", 32'h44 - 32'(i * 16));
    end
    checkOutput("unf_before_empty", 32'(RAS_UNF), 32'h0);
    applyStimulus(1'b0, 3'd5, 1'b0, 8'h00, 32'h0);
    expectPc("ret_after_ovf", 32'h18);
    checkOutput("underflow_flag", 32'(RAS_UNF), 32'h1);

    resetPulse();
    applyStimulus(1'b0, 3'd6, 1'b0, 8'h00, 32'h40);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'd4, 1'b0, 8'h04, 32'h0);
      expectPc("stalled_call", 32'h40);
    end
    applyStimulus(1'b0, 3'd4, 1'b0, 8'h04, 32'h0);
    expectPc("unstalled_call", 32'h54);
    applyStimulus(1'b0, 3'd5, 1'b0, 8'h00, 32'h0);
    expectPc("single_push_ret", 32'h44);
    applyStimulus(1'b0, 3'd5, 1'b0, 8'h00, 32'h0);
    expectPc("single_push_empty", 32'h48);
    applyStimulus(1'b1, 3'd4, 1'b0, 8'h04, 32'h0);
    resetPulse();

    applyStimulus(1'b0, 3'd6, 1'b0, 8'h00, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 3'd0, 1'b0, 8'h00, 32'h0);
    expectPc("seq_wrap", 32'h0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        resetPulse();
      end
      applyStimulus(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    8'($urandom), $urandom);
    end

    repeat (3) @(negedge CLK);
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised successor of the processor's program-counter unit.
- Generates the fetch address each cycle. Supports:
  - sequential execution
  - conditional branches on ZERO (BEQ/BNE)
  - unconditional jump
  - register jump
  - CALL/RET through an internal return-address stack (RAS)
- Honours a fetch-stall input from instruction memory.
- Sits between the control unit/ALU and instruction memory in the single-cycle datapath.

Parameters:
- ADDR_W, 32, PC/address width in bits (>= 8).
- OFFSET_W, 8, width of the signed word offset in the instruction.
- RAS_DEPTH, 4, number of return-address stack entries (power of two, >= 2).
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- CLK  in  1  system clock, rising-edge active.
- RESET  in  1  asynchronous, active-low reset.
- STALL  in  1  1 = hold PC and RAS this cycle (memory busywait).
- BRANCH  in  3  mode: 000 SEQ, 001 BEQ, 010 BNE, 011 JUMP, 100 CALL, 101 RET, 110 JREG, 111 reserved (treated as SEQ).
- ZERO  in  1  ALU zero flag.
- OFFSET  in  OFFSET_W  signed word offset.
- JREG_TARGET  in  ADDR_W  register-supplied absolute target for JREG.
- PC  out  ADDR_W  current fetch address.
- NEXT_PC  out  ADDR_W  combinational value PC will take at the next unstalled edge.
- TAKEN  out  1  combinational; 1 when NEXT_PC != PC+4 selection (redirect).
- RAS_OVF  out  1  sticky; set when CALL pushes onto a full RAS.
- RAS_UNF  out  1  sticky; set when RET pops an empty RAS.

Behaviour:
- Reset (RESET low, asynchronous): PC=RESET_VECTOR, RAS emptied (count=0, pointer=0), RAS_OVF=0, RAS_UNF=0. Reset asserted mid-operation aborts any pending push/pop.
- Update: on rising CLK with RESET high and STALL=0, PC<=NEXT_PC. With STALL=1, PC, RAS contents, pointer, count and sticky flags all hold. NEXT_PC/TAKEN still evaluate.
- Arithmetic:
  - seq = PC+4, mod 2^ADDR_W, wraps silently.
  - rel = seq + (sign_extend(OFFSET) << 2), mod 2^ADDR_W.
  - No inserted # delays; pure RTL.
- NEXT_PC selection:
  - SEQ/reserved: seq.
  - BEQ: rel if ZERO=1, else seq.
  - BNE: rel if ZERO=0, else seq.
  - JUMP: rel.
  - CALL: rel; push seq.
  - RET: top-of-stack if count>0, else seq.
  - JREG: JREG_TARGET, used as-is; no alignment check unless the optional feature is enabled.
- TAKEN = 1 whenever the selected source is not seq, including RET with count>0. A RET on an empty stack gives TAKEN=0.
- RAS is a circular LIFO:
  - Push writes at the pointer, then pointer++. Count saturates at RAS_DEPTH.
  - Push when full overwrites the oldest entry (circular wrap) and sets RAS_OVF.
  - Pop reads entry pointer-1, then pointer--, count--.
  - Pop when empty: no pointer change, sets RAS_UNF.
  - A single instruction is either push or pop, never both.
  - Push/pop commit only on an unstalled edge.
- Sticky flags clear only on reset.

Optional Feature:
- Macro PC_MISALIGN_TRAP_EN.
- When defined:
  - Adds parameter TRAP_VECTOR (default 'h10) and output MISALIGN (1 bit, sticky, reset 0).
  - If the selected NEXT_PC has bits[1:0]!=0, NEXT_PC becomes TRAP_VECTOR, TAKEN=1 and MISALIGN sets on the committing edge.
  - A CALL whose target is misaligned does not push.
- When undefined: no port, no check; misaligned JREG targets pass through unchanged.

Decomposition:
- Package pc_pkg:
  - BRANCH mode encodings (PC_SEQ, PC_BEQ, PC_BNE, PC_JUMP, PC_CALL, PC_RET, PC_JREG)
  - constant PC_STEP=4
  - helper for sign-extend-and-shift of OFFSET
- One natural sub-module: pc_ras. It holds the circular stack, pointer, count and overflow/underflow detection, with ports push, pop, push_data, top, empty, full.

Test Plan:
- Reset low at t0, release, 4 unstalled SEQ cycles -> PC sequence 0,4,8,12,16; TAKEN=0 throughout.
- PC=0x20, BEQ, OFFSET=-2 (0xFE), ZERO=1 -> PC=0x1C. Repeat with ZERO=0 -> PC=0x24. BNE, ZERO=0, OFFSET=3 -> PC=PC+16.
- From PC=0x40: CALL, OFFSET=4 -> PC=0x54, RAS top=0x44. Then RET -> PC=0x44, stack empty. A further RET -> PC=0x48, RAS_UNF=1, TAKEN=0.
- RAS_DEPTH=4: five nested CALLs from PCs 0x00,0x10,0x20,0x30,0x40 -> RAS_OVF=1. Five RETs return 0x44,0x34,0x24,0x14, then empty (RAS_UNF sets on the 5th).
- STALL=1 for 3 cycles during CALL -> PC, count unchanged and no push. STALL drops -> exactly one push and PC=rel. Async reset pulse mid-stall -> PC=RESET_VECTOR immediately, flags 0.
- ADDR_W=8, PC=0xFC, SEQ -> PC=0x00 (wrap). With PC_MISALIGN_TRAP_EN: JREG target 0x6A -> PC=TRAP_VECTOR, MISALIGN=1.
